// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution accumulator slice:
//   TAPS_DEFAULT  - default number of products summed per window
//   ACC_W_DEFAULT - default accumulator width (signed two's complement)
//   PIX_W         - width of the clipped pixel output
//   state_t       - accumulator FSM state encoding
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int TAPS_DEFAULT  = 9;
    localparam int ACC_W_DEFAULT = 20;
    localparam int PIX_W         = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : conv_pkg

// File: rtl/conv_sat_clip.sv
// ---------------------------------------------------------------------------
// conv_sat_clip
// Converts a signed window sum into an unsigned pixel: arithmetic right shift
// by SHIFT, then clamp to [0, 2**PIX_W - 1]. Purely combinational; the caller
// registers the result alongside the sum it was derived from.
// Only instantiated when CONV_ACC_SAT_OUT_EN is defined.
//
// Ports:
//   din  in  IN_W   signed window sum
//   pix  out PIX_W  clipped pixel value
// ---------------------------------------------------------------------------
module conv_sat_clip
    import conv_pkg::*;
#(
    parameter int IN_W  = ACC_W_DEFAULT,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0]  din,
    output logic [PIX_W-1:0] pix
);

    localparam logic signed [IN_W-1:0] PIX_MAX = IN_W'((1 << PIX_W) - 1);

    logic signed [IN_W-1:0] shifted;

    // NOTE: every output of a combinational block is assigned on every path
    // (here via the if/else chain after a default); a path that skips an
    // assignment would infer a latch.
    always_comb begin
        shifted = $signed(din) >>> SHIFT;
        pix     = '0;
        if (shifted[IN_W-1]) begin
            pix = '0;
        end else if (shifted > PIX_MAX) begin
            pix = '1;
        end else begin
            pix = shifted[PIX_W-1:0];
        end
    end

endmodule : conv_sat_clip

// File: rtl/conv_accumulator.sv
// ---------------------------------------------------------------------------
// conv_accumulator
// Sums TAPS signed 16-bit products (one per prod_vld strobe, any gap between
// them) into a wrapping ACC_W-bit accumulator. On the edge that accepts the
// last product the sum is published on acc_out with a one-cycle acc_vld pulse
// and a sticky-per-window signed overflow flag on ovf. clear aborts the
// window without publishing; acc_out/ovf keep their last reported values.
//
// Optional feature (macro CONV_ACC_SAT_OUT_EN): adds pix_out, the reported
// sum shifted right by SHIFT and clamped to 0..255, updated with acc_out.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   prod_in   in   16  signed product
//   prod_vld  in   product strobe
//   clear     in   synchronous window abort (wins over prod_vld)
//   acc_out   out  ACC_W signed window sum, held between windows
//   acc_vld   out  one-cycle pulse when acc_out updates
//   tap_cnt   out  4   products accepted in the current window
//   busy      out  high while a window is open (state ACCUM)
//   ovf       out  signed overflow seen in the reported window
//   pix_out   out  8   clipped pixel (CONV_ACC_SAT_OUT_EN only)
// ---------------------------------------------------------------------------
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int TAPS  = TAPS_DEFAULT,
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      prod_in,
    input  logic             prod_vld,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_vld,
    output logic [3:0]       tap_cnt,
    output logic             busy,
    output logic             ovf
`ifdef CONV_ACC_SAT_OUT_EN
    ,
    output logic [PIX_W-1:0] pix_out
`endif
);

    // Products are sign-extended into the accumulator, so it must be at least
    // as wide as a product; tap_cnt is 4 bits wide.
    if (TAPS < 1 || TAPS > 15 || ACC_W < 16 || SHIFT < 0) begin : g_bad_params
        $error("conv_accumulator: illegal TAPS/ACC_W/SHIFT combination");
    end

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf_int;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [3:0]       next_cnt;
    logic             last_tap;

    // The first product of a window is added to zero rather than to acc, so
    // one adder serves both the load and the accumulate case, and the load
    // can never flag an overflow.
    always_comb begin
        prod_ext = ACC_W'($signed(prod_in));
        addend   = (state == ACCUM) ? acc : '0;
        sum      = addend + prod_ext;
        // Signed overflow: operands share a sign that the result does not.
        add_ovf  = (addend[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != addend[ACC_W-1]);
        next_cnt = tap_cnt + 4'd1;
        last_tap = (next_cnt == 4'(TAPS));
    end

`ifdef CONV_ACC_SAT_OUT_EN
    logic [PIX_W-1:0] pix_next;

    conv_sat_clip #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT)
    ) u_clip (
        .din (sum),
        .pix (pix_next)
    );
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking assignments here would let later
    // statements see already-updated state and break the one-cycle timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ovf_int <= 1'b0;
            acc_out <= '0;
            acc_vld <= 1'b0;
            tap_cnt <= 4'd0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
`ifdef CONV_ACC_SAT_OUT_EN
            pix_out <= '0;
`endif
        end else begin
            acc_vld <= 1'b0;
            if (clear) begin
                // Abort: drop any product this cycle; reported outputs hold.
                state   <= IDLE;
                acc     <= '0;
                ovf_int <= 1'b0;
                tap_cnt <= 4'd0;
                busy    <= 1'b0;
            end else if (prod_vld) begin
                if (last_tap) begin
                    state   <= IDLE;
                    acc     <= '0;
                    ovf_int <= 1'b0;
                    tap_cnt <= 4'd0;
                    busy    <= 1'b0;
                    acc_out <= sum;
                    acc_vld <= 1'b1;
                    ovf     <= ovf_int | add_ovf;
`ifdef CONV_ACC_SAT_OUT_EN
                    pix_out <= pix_next;
`endif
                end else begin
                    state   <= ACCUM;
                    acc     <= sum;
                    ovf_int <= ovf_int | add_ovf;
                    tap_cnt <= next_cnt;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule : conv_accumulator

// File: doc/conv_accumulator.md
CONV_ACCUMULATOR -- requirements
Module: conv_accumulator

Interface
REQ-001 Parameter TAPS, default 9, number of products summed per convolution window (1..15).
REQ-002 Parameter ACC_W, default 20, accumulator width in bits, signed two's complement.
REQ-003 Parameter SHIFT, default 0, arithmetic right shift applied before pixel clipping.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 prod_in  input  16  signed product from the upstream multiplier.
REQ-007 prod_vld  input  1  single-cycle strobe; prod_in valid this cycle.
REQ-008 clear  input  1  synchronous abort of the current window.
REQ-009 acc_out  output  ACC_W  signed window sum, held until the next window completes.
REQ-010 acc_vld  output  1  one-cycle pulse; acc_out updated this cycle.
REQ-011 tap_cnt  output  4  number of products accepted in the current window.
REQ-012 busy  output  1  high while in state ACCUM.
REQ-013 ovf  output  1  signed overflow flag for the window just reported; valid with acc_vld and held afterwards.

Function
REQ-014 The FSM SHALL have two states: IDLE and ACCUM.
REQ-015 IDLE + prod_vld: acc = sext(prod_in), tap_cnt = 1, next ACCUM; if TAPS==1, complete the window instead (REQ-017).
REQ-016 ACCUM + prod_vld: acc = acc + sext(prod_in), tap_cnt increments.
REQ-017 On the edge accepting the TAPS-th product: acc_out <= final sum, acc_vld <= 1 for exactly one cycle, tap_cnt <= 0, next IDLE; latency is 1 cycle from the final prod_vld.
REQ-018 Cycles without prod_vld SHALL leave acc, tap_cnt and state unchanged; gaps between products are unlimited.
REQ-019 Back-to-back: a prod_vld in the cycle that acc_vld is high SHALL be accepted as tap 1 of the next window.
REQ-020 clear SHALL force IDLE, acc = 0, tap_cnt = 0, internal overflow tracking = 0, and no acc_vld pulse; acc_out and ovf hold their last values.
REQ-021 clear and prod_vld in the same cycle: clear wins and the product is dropped.
REQ-022 Addition SHALL wrap at ACC_W bits; an internal overflow bit SHALL be set when any add in the window produces signed overflow.
REQ-023 ovf SHALL be loaded from the internal overflow bit on the completing edge.
REQ-024 No backpressure: the block SHALL always accept prod_vld.

Reset
REQ-025 rst SHALL asynchronously set: state IDLE, acc 0, acc_out 0, acc_vld 0, tap_cnt 0, busy 0, ovf 0, and pix_out 0 when present.
REQ-026 rst asserted mid-window SHALL discard the partial sum; the first prod_vld after release starts a new window.

Configuration
REQ-027 Macro CONV_ACC_SAT_OUT_EN is defined: add output pix_out[7:0] = clamp(acc_out >>> SHIFT, 0, 255), registered with the same timing as acc_out.
REQ-028 Macro CONV_ACC_SAT_OUT_EN is undefined: pix_out port and clip logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package conv_pkg SHALL hold the TAPS and ACC_W defaults, PIX_W=8, and the FSM state enum type.
REQ-030 Clip logic SHALL be the sub-module conv_sat_clip, instantiated only under CONV_ACC_SAT_OUT_EN.

Verification
REQ-031 Nine prod_vld with prod_in=1, one per cycle -> acc_vld one cycle after the 9th, acc_out=9, ovf=0.
REQ-032 Nine products of -32768 with 2-cycle gaps -> acc_out=-294912, ovf=0, busy high throughout.
REQ-033 Four products, then clear with a simultaneous prod_vld, then nine products of 2 -> single acc_vld, acc_out=18.
REQ-034 ACC_W=16 with products 20000, 20000, 0 x7 -> ovf=1, acc_out=wrapped 40000 (-25536).
REQ-035 rst pulsed after 5 products, then nine products of 3 -> acc_out=27; back-to-back second window of 1s -> acc_out=9 with no idle cycle.
REQ-036 CONV_ACC_SAT_OUT_EN, SHIFT=0: window sum -50 -> pix_out=0; sum 300 -> pix_out=255; sum 77 -> pix_out=77.
